key_capture_debounce: RTL and testbench
=======================================

Name: key_capture_debounce

Overview:
- Sits directly downstream of the keypad row-scan FSM and consumes its keyPressed and keyDecoded[3:0] outputs.
- Debounces press and release with a cycle counter and registers exactly one key per physical press.
- Maintains a two-digit history for the seven-segment display mux: the newest key goes in digit_new and the previous key shifts into digit_old.
- Also emits a one-cycle key_strobe for any other consumer.

Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive stable clk cycles needed to accept a press or a release (about 20 ms at 2.4 MHz).
- CNT_W, default 16: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- keyPressed, input, 1: a column is active on the currently scanned row.
- keyDecoded, input, 4: hex code of the key on the active row/column.
- digit_new, output, 4: most recently accepted key.
- digit_old, output, 4: key accepted before digit_new.
- key_strobe, output, 1: one-cycle pulse when a key is accepted.
- key_held, output, 1: high from acceptance until the release is debounced.

Behaviour:
- Reset (reset==0, async): state=IDLE, cnt=0, cand=0, digit_new=0, digit_old=0, key_strobe=0, key_held=0.
- All registers update on posedge clk. Inputs are asynchronous to the keypad, so keyPressed and keyDecoded each pass through a 2-flop synchronizer; this adds 2 cycles of latency, and all counts below refer to the synchronized signals (kp_s, kd_s).
- States (enum in package): IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - If kp_s=1: cand<=kd_s, cnt<=0, go to PRESS_WAIT.
  - Otherwise stay in IDLE.
- PRESS_WAIT:
  - If kp_s=0 or kd_s!=cand: go to IDLE, cnt<=0. Bounce or key change aborts the attempt.
  - Else if cnt==DEBOUNCE_CYCLES-1: accept the key. digit_old<=digit_new, digit_new<=cand, key_strobe=1 for exactly that cycle, go to HELD, cnt<=0.
  - Else cnt<=cnt+1.
- HELD:
  - key_held=1.
  - If kp_s=0: cnt<=0, go to RELEASE_WAIT.
  - A change of kd_s while kp_s=1 (second key, or the scanner moving rows) is ignored. No new capture happens until release.
- RELEASE_WAIT:
  - key_held=1.
  - If kp_s=1: return to HELD with cnt<=0 (release bounce).
  - Else if cnt==DEBOUNCE_CYCLES-1: go to IDLE.
  - Else cnt<=cnt+1.
- Latency: key_strobe asserts exactly DEBOUNCE_CYCLES+3 clk cycles after keyPressed first rises and stays stable (2 sync + 1 IDLE + DEBOUNCE_CYCLES).
- Same key pressed twice: both presses register, and digit_old==digit_new is legal.
- Counter never wraps. It resets on every state entry and saturates at its compare value.
- key_strobe never asserts on two consecutive cycles.
- Reset mid-press: everything clears immediately. A key still held when reset deasserts is treated as a new press and registers after a full debounce.
- Illegal state encoding: default branch goes to IDLE.

Decomposition:
- Package keypad_pkg:
  - typedef enum logic [1:0] capstate_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Localparam DEBOUNCE_DEFAULT = 50000.
- One sub-module, sync2: a 2-flop synchronizer with a width parameter and async active-low reset. Instantiate it twice: width 1 for keyPressed, width 4 for keyDecoded.
- The FSM, counter and digit shift register stay in key_capture_debounce.

Test Plan (run with DEBOUNCE_CYCLES=8):
- Reset, then clean press: hold keyPressed=1 with keyDecoded=4'h5 for 20 cycles.
  - key_strobe pulses once, at cycle 11 after the rise.
  - digit_new=5, digit_old=0, key_held=1 until 11 cycles after release.
- Bounce on press: toggle keyPressed 1/0 every 3 cycles 5 times, then hold keyDecoded=4'hA.
  - Exactly one strobe, 11 cycles after the final stable rise.
  - digit_new=A.
- Sequence: press 3, release, press 7, release, press 7 (each held 20 cycles, idle 20 cycles between).
  - Three strobes.
  - Final state: digit_new=7, digit_old=7.
  - After the second press: digit_new=7, digit_old=3.
- Release bounce: after accepting key 2, drop keyPressed for 4 cycles, raise it for 2, then drop it permanently.
  - No second strobe.
  - key_held falls 11 cycles after the final drop.
- Second key while held: accept 1, then change keyDecoded to 4'hC with keyPressed still high.
  - No strobe.
  - digit_new stays 1.
- Async reset mid-debounce: assert reset=0 on cycle 5 of PRESS_WAIT (not clock-aligned).
  - Outputs go to 0 immediately, with no strobe.
  - After deassert with the key still held, one strobe occurs 11 cycles later.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the keypad capture path: capture FSM states and the
// default debounce length.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } capstate_t;

  localparam int DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/key_capture_debounce_sync2.sv
// Two-flop synchronizer for signals arriving from the keypad scanner's
// timing domain; async active-low reset clears both stages.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_capture_debounce.sv
// Debounces keypad press/release, captures one key per physical press into a
// two-digit history and pulses key_strobe on each accepted key.
module key_capture_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyPressed,
  input  logic [3:0] keyDecoded,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_strobe,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_kp_s;
  logic [3:0]       w_kd_s;
  capstate_t        r_state;
  capstate_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_next;
  logic             w_accept;
  logic [3:0]       r_digit_new;
  logic [3:0]       r_digit_old;
  logic             r_key_strobe;

  sync2 #(.W(1)) u_sync_kp (
    .clk    (clk),
    .i_rst_n(reset),
    .i_d    (keyPressed),
    .o_q    (w_kp_s)
  );

  sync2 #(.W(4)) u_sync_kd (
    .clk    (clk),
    .i_rst_n(reset),
    .i_d    (keyDecoded),
    .o_q    (w_kd_s)
  );

  // Counter is cleared on every state entry, so it never exceeds CNT_LAST.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_kp_s) begin
          w_cand_next  = w_kd_s;
          w_cnt_next   = '0;
          w_state_next = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!w_kp_s || (w_kd_s != r_cand)) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_accept     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = HELD;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        // Key code changes while still pressed are ignored until release.
        if (!w_kp_s) begin
          w_cnt_next   = '0;
          w_state_next = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (w_kp_s) begin
          w_cnt_next   = '0;
          w_state_next = HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_cand       <= '0;
      r_digit_new  <= '0;
      r_digit_old  <= '0;
      r_key_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_cand       <= w_cand_next;
      r_key_strobe <= w_accept;
      if (w_accept) begin
        r_digit_old <= r_digit_new;
        r_digit_new <= r_cand;
      end
    end
  end

  assign digit_new  = r_digit_new;
  assign digit_old  = r_digit_old;
  assign key_strobe = r_key_strobe;
  assign key_held   = (r_state == HELD) || (r_state == RELEASE_WAIT);

endmodule

// File: tb/tb_key_capture_debounce.sv
// Randomized and directed bench for key_capture_debounce with a run-length
// reference model of the debounce rules (DEBOUNCE_CYCLES = 8).
module tb_key_capture_debounce;

  localparam int N   = 8;
  localparam int LAT = N + 3;

  logic       clk;
  logic       reset;
  logic       keyPressed;
  logic [3:0] keyDecoded;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_strobe;
  logic       key_held;

  key_capture_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .keyPressed(keyPressed),
    .keyDecoded(keyDecoded),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .key_strobe(key_strobe),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: inputs seen two clocks late; a key is accepted after
  // N+1 consecutive pressed samples while not held, and released after N+1
  // consecutive unpressed samples while held.
  logic       m_pipe_kp[2];
  logic [3:0] m_pipe_kd[2];
  int         m_ones, m_zeros;
  bit         m_held, m_strobe;
  logic [3:0] m_keys[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pipe_kp[i] = 1'b0;
      m_pipe_kd[i] = 4'h0;
    end
    m_ones = 0; m_zeros = 0; m_held = 0; m_strobe = 0;
    m_keys.delete();
  endtask

  task automatic model_edge(input logic kp, input logic [3:0] kd);
    logic       s_kp;
    logic [3:0] s_kd;
    s_kp = m_pipe_kp[1];
    s_kd = m_pipe_kd[1];
    m_pipe_kp[1] = m_pipe_kp[0]; m_pipe_kd[1] = m_pipe_kd[0];
    m_pipe_kp[0] = kp;           m_pipe_kd[0] = kd;
    m_strobe = 0;
    if (s_kp) begin m_ones++; m_zeros = 0; end
    else      begin m_zeros++; m_ones = 0; end
    if (!m_held && m_ones == N + 1) begin
      m_keys.push_back(s_kd);
      m_held = 1; m_strobe = 1;
    end else if (m_held && m_zeros == N + 1) begin
      m_held = 0;
    end
  endtask

  function automatic logic [3:0] exp_new();
    return (m_keys.size() > 0) ? m_keys[m_keys.size()-1] : 4'h0;
  endfunction

  function automatic logic [3:0] exp_old();
    return (m_keys.size() > 1) ? m_keys[m_keys.size()-2] : 4'h0;
  endfunction

  int cyc = 0;
  int n_strobe = 0;
  int last_strobe_cyc = -1;
  int held_fall_cyc = -1;
  bit prev_held = 0;
  bit prev_strobe = 0;

  // One clock: drive now, let the edge happen, compare 1 time unit later,
  // then return on the following negedge.
  task automatic step(input logic kp, input logic [3:0] kd);
    keyPressed = kp;
    keyDecoded = kd;
    @(posedge clk);
    model_edge(kp, kd);
    #1;
    cyc++;
    check_val("strobe", {31'd0, key_strobe}, {31'd0, m_strobe});
    check_val("held",   {31'd0, key_held},   {31'd0, m_held});
    check_val("dnew",   {28'd0, digit_new},  {28'd0, exp_new()});
    check_val("dold",   {28'd0, digit_old},  {28'd0, exp_old()});
    if (key_strobe) begin
      check_val("strobe_consec", {31'd0, prev_strobe}, 32'd0);
      n_strobe++;
      last_strobe_cyc = cyc;
      $display("cyc %0d key accepted: digit_new=%h digit_old=%h", cyc, digit_new, digit_old);
    end
    if (prev_held && !key_held) held_fall_cyc = cyc;
    prev_held   = key_held;
    prev_strobe = key_strobe;
    @(negedge clk);
  endtask

  task automatic hold(input logic kp, input logic [3:0] kd, input int n);
    for (int i = 0; i < n; i++) step(kp, kd);
  endtask

  int c0, s0;
  logic       r_kp;
  logic [3:0] r_kd;
  int         r_len;

  initial begin
    reset = 1'b0; keyPressed = 1'b0; keyDecoded = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_dnew",   {28'd0, digit_new}, 32'd0);
    check_val("rst_dold",   {28'd0, digit_old}, 32'd0);
    check_val("rst_strobe", {31'd0, key_strobe}, 32'd0);
    check_val("rst_held",   {31'd0, key_held}, 32'd0);
    reset = 1'b1;

    // Clean press of 5
    c0 = cyc; s0 = n_strobe;
    hold(1'b1, 4'h5, 20);
    check_val("clean_lat",   last_strobe_cyc - c0, LAT);
    check_val("clean_count", n_strobe - s0, 1);
    check_val("clean_dnew",  {28'd0, digit_new}, 32'h5);
    check_val("clean_dold",  {28'd0, digit_old}, 32'h0);
    check_val("clean_held",  {31'd0, key_held}, 32'd1);
    c0 = cyc;
    hold(1'b0, 4'h5, 20);
    check_val("clean_rel_lat", held_fall_cyc - c0, LAT);

    // Press bounce then stable A
    s0 = n_strobe;
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 4'hA, 3);
      hold(1'b0, 4'hA, 3);
    end
    c0 = cyc;
    hold(1'b1, 4'hA, 20);
    check_val("bounce_count", n_strobe - s0, 1);
    check_val("bounce_lat",   last_strobe_cyc - c0, LAT);
    check_val("bounce_dnew",  {28'd0, digit_new}, 32'hA);
    hold(1'b0, 4'hA, 20);

    // Sequence 3, 7, 7
    s0 = n_strobe;
    hold(1'b1, 4'h3, 20); hold(1'b0, 4'h3, 20);
    hold(1'b1, 4'h7, 20);
    check_val("seq2_dnew", {28'd0, digit_new}, 32'h7);
    check_val("seq2_dold", {28'd0, digit_old}, 32'h3);
    hold(1'b0, 4'h7, 20);
    hold(1'b1, 4'h7, 20);
    check_val("seq_count", n_strobe - s0, 3);
    check_val("seq_dnew",  {28'd0, digit_new}, 32'h7);
    check_val("seq_dold",  {28'd0, digit_old}, 32'h7);
    hold(1'b0, 4'h7, 20);

    // Release bounce on key 2
    s0 = n_strobe;
    hold(1'b1, 4'h2, 20);
    held_fall_cyc = -1;
    hold(1'b0, 4'h2, 4);
    hold(1'b1, 4'h2, 2);
    check_val("relb_no_fall", held_fall_cyc, -1);
    c0 = cyc;
    hold(1'b0, 4'h2, 20);
    check_val("relb_count", n_strobe - s0, 1);
    check_val("relb_fall",  held_fall_cyc - c0, LAT);

    // Second key while held
    s0 = n_strobe;
    hold(1'b1, 4'h1, 20);
    hold(1'b1, 4'hC, 15);
    check_val("second_count", n_strobe - s0, 1);
    check_val("second_dnew",  {28'd0, digit_new}, 32'h1);
    hold(1'b0, 4'hC, 20);

    // Async reset in the middle of the press debounce
    s0 = n_strobe;
    hold(1'b1, 4'h6, 7);
    #2 reset = 1'b0;
    #1;
    check_val("areset_dnew",   {28'd0, digit_new}, 32'h0);
    check_val("areset_dold",   {28'd0, digit_old}, 32'h0);
    check_val("areset_strobe", {31'd0, key_strobe}, 32'd0);
    check_val("areset_held",   {31'd0, key_held}, 32'd0);
    check_val("areset_nostrobe", n_strobe - s0, 0);
    model_reset();
    prev_held = 0; prev_strobe = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    c0 = cyc;
    hold(1'b1, 4'h6, 20);
    check_val("areset_count", n_strobe - s0, 1);
    check_val("areset_lat",   last_strobe_cyc - c0, LAT);
    check_val("areset_dnew2", {28'd0, digit_new}, 32'h6);
    hold(1'b0, 4'h6, 20);

    // Random runs: key code only changes while the key is up
    r_kd = 4'h0;
    for (int r = 0; r < 60; r++) begin
      r_kp  = 1'($urandom_range(0, 1));
      r_len = int'($urandom_range(1, 14));
      if (!r_kp) r_kd = 4'($urandom_range(0, 15));
      hold(r_kp, r_kd, r_len);
    end
    hold(1'b0, r_kd, 20);
    check_val("rand_idle_held", {31'd0, key_held}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
